// File: rtl/regarb_pkg.sv
// Shared defaults and constants for the register-file write arbiter.
package regarb_pkg;

    localparam int unsigned NREQ_DEF   = 3;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 31;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PTR_W = ptr_width(NREQ_DEF);

endpackage

// File: rtl/rr_select.sv
// Picks the first requester at or above ptr (wrapping modulo NREQ); one-hot or zero result.
module rr_select
    import regarb_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned PTR_W_P = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]    req,
    input  logic [PTR_W_P-1:0] ptr,
    output logic [NREQ-1:0]    grant_c
);

    always_comb begin : sel
        logic        found;
        int unsigned idx;
        grant_c = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    grant_c[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NREQ writers onto one register-file write port with one-cycle registered write.
// Define WRARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic                   block,
    output logic [NREQ-1:0]        grant,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data
);

    localparam int unsigned PW = ptr_width(NREQ);

    logic [NREQ-1:0]   req_eff_c;
    logic [PW-1:0]     ptr_c;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // Nothing is granted while blocked or held in reset.
    assign req_eff_c = (block || !reset) ? '0 : req;

`ifdef WRARB_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;
    assign ptr_c = ptr_q;
`else
    assign ptr_c = '0;
`endif

    rr_select #(
        .NREQ    (NREQ),
        .PTR_W_P (PW)
    ) u_rr_select (
        .req     (req_eff_c),
        .ptr     (ptr_c),
        .grant_c (grant)
    );

    // Capture the granted requester's payload; zero-register writes are consumed but not enabled.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef WRARB_RR_EN
        ptr_d     = ptr_q;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                wr_addr_d = req_addr[i*ADDR_W +: ADDR_W];
                wr_data_d = req_data[i*DATA_W +: DATA_W];
                wr_en_d   = (req_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG));
`ifdef WRARB_RR_EN
                ptr_d     = (i == NREQ - 1) ? '0 : PW'(i + 1);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef WRARB_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef WRARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
